// File: rtl/cmos_splice_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmos_splice_pkg : shared types and defaults for the splice ctrl  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package cmos_splice_pkg;

  localparam int c_H_ACT   = 640;
  localparam int c_OFFSET  = 98;
  localparam int c_H_BLANK = 16;
  localparam int c_V_LINES = 480;

  localparam int c_PCNT_W  = 11;
  localparam int c_LINE_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD0   = 3'd3,
    ST_DROP1 = 3'd4,
    ST_BLANK = 3'd5
  } splice_state_t;

endpackage
`default_nettype wire

// File: rtl/cmos_vsync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmos_vsync_edge : registered rising-edge detector / 1-cycle delay|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module cmos_vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_sig_dly,
  output logic o_sig_rise
);

  logic r_sig_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_dly <= 1'b0;
    end else begin
      r_sig_dly <= i_sig;
    end
  end

  assign o_sig_dly  = r_sig_dly;
  assign o_sig_rise = i_sig & ~r_sig_dly;

endmodule
`default_nettype wire

// File: rtl/cmos_splice_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cmos_splice_ctrl : per-line read scheduler for dual-camera splice|
// | Optional: SPLICE_UNDERFLOW_CHK_EN enables sticky underflow flag.  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module cmos_splice_ctrl
  import cmos_splice_pkg::*;
#(
  parameter int H_ACT   = c_H_ACT,
  parameter int OFFSET  = c_OFFSET,
  parameter int H_BLANK = c_H_BLANK,
  parameter int V_LINES = c_V_LINES
) (
  input  logic                cmos0_pclk,
  input  logic                sys_rst_n,
  input  logic                cam0_vsync,
  input  logic                splice_mode,
  input  logic                cam0_line_rdy,
  input  logic                cam1_line_rdy,
  input  logic                cam0_empty,
  input  logic                cam1_empty,
  output logic                cam0_rd_en,
  output logic                cam1_rd_en,
  output logic                pix_sel,
  output logic                pixel_href,
  output logic                pixel_vsync,
  output logic [c_LINE_W-1:0] line_cnt,
  output logic                underflow
);

  localparam logic [c_PCNT_W-1:0] c_LEN_FULL  = c_PCNT_W'(H_ACT - 1);
  localparam logic [c_PCNT_W-1:0] c_LEN_OFF   = c_PCNT_W'(OFFSET - 1);
  localparam logic [c_PCNT_W-1:0] c_LEN_DROP  = c_PCNT_W'(H_ACT - OFFSET - 1);
  localparam logic [c_PCNT_W-1:0] c_LEN_BLANK = c_PCNT_W'(H_BLANK - 1);
  localparam logic [c_LINE_W-1:0] c_LAST_LINE = c_LINE_W'(V_LINES - 1);

  splice_state_t       r_state;
  logic [c_PCNT_W-1:0] r_pcnt;
  logic [c_LINE_W-1:0] r_line;
  logic                r_mode;
  logic                r_cam0_rd;
  logic                r_cam1_rd;
  logic                r_href;
  logic                r_pix_sel;
  logic                w_vs_rise;
  logic                w_rd1_end;

  cmos_vsync_edge u_vsync_edge (
    .clk        (cmos0_pclk),
    .rst_n      (sys_rst_n),
    .i_sig      (cam0_vsync),
    .o_sig_dly  (pixel_vsync),
    .o_sig_rise (w_vs_rise)
  );

  assign w_rd1_end = (r_pcnt == (r_mode ? c_LEN_OFF : c_LEN_FULL));

  // href/pix_sel trail the read enables by one cycle to line up with FIFO Q
  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_pcnt    <= '0;
      r_line    <= '0;
      r_mode    <= 1'b0;
      r_cam0_rd <= 1'b0;
      r_cam1_rd <= 1'b0;
      r_href    <= 1'b0;
      r_pix_sel <= 1'b0;
    end else begin
      r_href    <= (r_state == ST_RD1) || (r_state == ST_RD0);
      r_pix_sel <= (r_state == ST_RD0);
      if (w_vs_rise) begin
        r_state   <= ST_WAIT;
        r_pcnt    <= '0;
        r_line    <= '0;
        r_mode    <= splice_mode;
        r_cam0_rd <= 1'b0;
        r_cam1_rd <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cam0_rd <= 1'b0;
            r_cam1_rd <= 1'b0;
          end
          ST_WAIT: begin
            if (cam0_line_rdy && cam1_line_rdy) begin
              r_state   <= ST_RD1;
              r_pcnt    <= '0;
              r_cam1_rd <= 1'b1;
            end
          end
          ST_RD1: begin
            if (w_rd1_end) begin
              r_state   <= ST_RD0;
              r_pcnt    <= '0;
              r_cam1_rd <= 1'b0;
              r_cam0_rd <= 1'b1;
            end else begin
              r_pcnt <= r_pcnt + c_PCNT_W'(1);
            end
          end
          ST_RD0: begin
            if (r_pcnt == c_LEN_FULL) begin
              r_pcnt    <= '0;
              r_cam0_rd <= 1'b0;
              if (r_mode) begin
                r_state   <= ST_DROP1;
                r_cam1_rd <= 1'b1;
              end else begin
                r_state <= ST_BLANK;
              end
            end else begin
              r_pcnt <= r_pcnt + c_PCNT_W'(1);
            end
          end
          ST_DROP1: begin
            if (r_pcnt == c_LEN_DROP) begin
              r_state   <= ST_BLANK;
              r_pcnt    <= '0;
              r_cam1_rd <= 1'b0;
            end else begin
              r_pcnt <= r_pcnt + c_PCNT_W'(1);
            end
          end
          ST_BLANK: begin
            if (r_pcnt == c_LEN_BLANK) begin
              r_pcnt  <= '0;
              r_line  <= r_line + c_LINE_W'(1);
              r_state <= (r_line == c_LAST_LINE) ? ST_IDLE : ST_WAIT;
            end else begin
              r_pcnt <= r_pcnt + c_PCNT_W'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_pcnt    <= '0;
            r_cam0_rd <= 1'b0;
            r_cam1_rd <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPLICE_UNDERFLOW_CHK_EN
  logic r_underflow;

  always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_underflow <= 1'b0;
    end else if (w_vs_rise) begin
      r_underflow <= 1'b0;
    end else if ((r_cam0_rd && cam0_empty) || (r_cam1_rd && cam1_empty)) begin
      r_underflow <= 1'b1;
    end
  end

  assign underflow = r_underflow;
`else
  logic w_unused_empty;
  assign w_unused_empty = cam0_empty ^ cam1_empty;
  assign underflow      = 1'b0;
`endif

  assign cam0_rd_en = r_cam0_rd;
  assign cam1_rd_en = r_cam1_rd;
  assign pix_sel    = r_pix_sel;
  assign pixel_href = r_href;
  assign line_cnt   = r_line;

endmodule
`default_nettype wire

// File: doc/cmos_splice_ctrl.md
# cmos_splice_ctrl

Line scheduler for the dual-camera splice path. Runs in the cmos0_pclk domain and sequences the two per-camera line FIFOs (cam1 FIFO and cam0 FIFO). For each output line it issues FIFO read enables in a fixed order and generates the stitched pixel_href, pixel_vsync and the data-select strobe for the output mux. Replaces ad-hoc href/empty gating with an explicit per-line state machine that supports side-by-side and offset-splice modes.

## Interface
- H_ACT, 640, pixels per camera line
- OFFSET, 98, cam1 pixels emitted before cam0 in offset mode (1..H_ACT-1)
- H_BLANK, 16, minimum href-low cycles between output lines
- V_LINES, 480, output lines per frame
- cmos0_pclk  in  1  clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- cam0_vsync  in  1  frame sync, synchronous to cmos0_pclk, active high
- splice_mode  in  1  0 = side-by-side, 1 = offset splice
- cam0_line_rdy  in  1  cam0 FIFO holds ≥ H_ACT words
- cam1_line_rdy  in  1  cam1 FIFO holds ≥ H_ACT words
- cam0_empty  in  1  cam0 FIFO empty
- cam1_empty  in  1  cam1 FIFO empty
- cam0_rd_en  out  1  cam0 FIFO read enable
- cam1_rd_en  out  1  cam1 FIFO read enable
- pix_sel  out  1  mux select aligned with FIFO Q: 0 = cam1, 1 = cam0
- pixel_href  out  1  stitched line valid
- pixel_vsync  out  1  cam0_vsync delayed 1 cycle
- line_cnt  out  10  current output line index
- underflow  out  1  sticky read-while-empty error

## Operation
- States: IDLE, WAIT, RD1, RD0, DROP1, BLANK; 11-bit pixel counter pcnt.
- IDLE: wait for a cam0_vsync rising edge -> WAIT. Latch splice_mode (mode_q); clear line_cnt and underflow.
- WAIT: when cam0_line_rdy & cam1_line_rdy -> RD1 with pcnt=0.
- RD1: cam1_rd_en=1. Length is H_ACT (mode_q=0) or OFFSET (mode_q=1), then -> RD0.
- RD0: cam0_rd_en=1 for H_ACT cycles. Next state is DROP1 if mode_q=1, else BLANK.
- DROP1: cam1_rd_en=1 for H_ACT-OFFSET cycles with href low. This discards the cam1 remainder so both FIFOs stay line-aligned. Then -> BLANK.
- BLANK: H_BLANK cycles, then line_cnt++.
  - If the completed line was V_LINES-1 -> IDLE.
  - Otherwise -> WAIT.
- Any cam0_vsync rising edge outside IDLE aborts the current line. It behaves exactly like the IDLE exit: -> WAIT, line_cnt=0, mode_q re-latched. Read enables drop in that same cycle.
- Output line length: 2·H_ACT in mode 0; OFFSET+H_ACT in mode 1.
- Underflow: set when cam0_rd_en&cam0_empty or cam1_rd_en&cam1_empty. Held until the next vsync rising edge or reset.
- pcnt compares use pcnt == len-1. Counters never wrap within a state.

## Timing
- FIFO read latency is 1 cycle. pix_sel and pixel_href are registered from state so they align with Q.
  - href rises 1 cycle after the first RD1 cycle and falls 1 cycle after the last RD0 cycle.
  - The RD1->RD0 transition is seamless: no href gap.
  - pix_sel changes on the cycle the first cam0 word appears.
- Reset values: all outputs 0, state IDLE, pcnt 0, mode_q 0.
- Vsync edge detection uses a 1-cycle delayed copy of the input. The edge acts on the cycle after the rise.
- line_rdy is sampled only in WAIT. A drop of line_rdy mid-line does not stall; underflow flags it.
- Simultaneous vsync edge and BLANK completion: the vsync edge wins.

## Configuration
- SPLICE_UNDERFLOW_CHK_EN defined: underflow logic present as specified.
- Not defined: underflow is tied to 0 and the empty inputs are unused.

## Structure
- Package cmos_splice_pkg holds:
  - the state enum;
  - default H_ACT/OFFSET/H_BLANK/V_LINES localparams;
  - width localparams for pcnt and line_cnt.
- One sub-module, cmos_vsync_edge: registered rising-edge detector. It is reusable for pixel_vsync delay.

## Test plan
- Mode 0, both FIFOs preloaded with 640 words: after a vsync rise, href is high for 1280 contiguous cycles. pix_sel is 0 for the first 640 and 1 for the last 640. There are 16 blank cycles, then line_cnt=1.
- Mode 1, OFFSET=98: href is high for 738 cycles with pix_sel switching after 98. cam1_rd_en pulses a further 542 cycles with href low. Total cam1 reads per line = 640.
- Vsync rise at pixel 300 of RD0: read enables drop on the next cycle and href falls one cycle later. line_cnt=0. The next line starts from RD1 once both line_rdy are set.
- cam1_line_rdy held low: the block stays in WAIT with href low and no reads. Raising it yields a line start 1 cycle later.
- With SPLICE_UNDERFLOW_CHK_EN, force cam0_empty=1 during RD0: underflow is set and stays 1 until the next vsync rise.
- V_LINES=4 small build: after 4 lines the block returns to IDLE and ignores line_rdy until a vsync rise.
